ram_ctrl: RTL and testbench

//  Request sequencer directly upstream of the 4x4 RAM. Accepts single-word read/write

---
 rtl/ram_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Request sequencer for the 4x4 RAM: valid/ready request port in, active-low RAM strobes out.
// Define RAM_CTRL_VERIFY_EN to add a read-back verify after every write (wr_err on mismatch).
module ram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              req_err,
  output logic              wr_err,
  output logic              ram_rd_ena,
  output logic              ram_wr_ena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

`ifdef RAM_CTRL_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAP, S_VRD, S_VCAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAP} state_t;
`endif

  // One extra bit so DEPTH == 2**ADDR_W is representable and never rejects.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_oor;
  logic                w_rd_ena_n;
  logic                w_wr_ena_n;
  logic                r_ram_rd_ena;
  logic                r_ram_wr_ena;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data_in;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_req_err;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_oor    = ({1'b0, req_addr} >= LP_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Enables are derived from the next state so the registered strobes line up with the state.
  always_comb begin
    w_next     = r_state;
    w_rd_ena_n = 1'b1;
    w_wr_ena_n = 1'b1;
    case (r_state)
      S_IDLE: if (w_accept && !w_oor) w_next = req_wr ? S_WR : S_RD;
`ifdef RAM_CTRL_VERIFY_EN
      S_WR:   w_next = S_VRD;
      S_VRD:  w_next = S_VCAP;
      S_VCAP: w_next = S_IDLE;
`else
      S_WR:   w_next = S_IDLE;
`endif
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
`ifdef RAM_CTRL_VERIFY_EN
    if (w_next == S_RD || w_next == S_VRD) w_rd_ena_n = 1'b0;
`else
    if (w_next == S_RD) w_rd_ena_n = 1'b0;
`endif
    if (w_next == S_WR) w_wr_ena_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_rd_ena  <= 1'b1;
      r_ram_wr_ena  <= 1'b1;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_req_err     <= 1'b0;
    end else begin
      r_ram_rd_ena <= w_rd_ena_n;
      r_ram_wr_ena <= w_wr_ena_n;
      if (w_accept && !w_oor) begin
        r_ram_addr <= req_addr;
        if (req_wr) r_ram_data_in <= req_wdata;
      end
      r_req_err   <= w_accept && w_oor;
      r_rsp_valid <= (r_state == S_CAP);
      if (r_state == S_CAP) r_rsp_rdata <= ram_data_out;
    end
  end

`ifdef RAM_CTRL_VERIFY_EN
  logic r_wr_err;

  // ram_data_in still holds the written word during VCAP, so it doubles as the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wr_err <= 1'b0;
    else        r_wr_err <= (r_state == S_VCAP) && (ram_data_out != r_ram_data_in);
  end

  assign wr_err = r_wr_err;
`else
  assign wr_err = 1'b0;
`endif

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign req_err     = r_req_err;
  assign ram_rd_ena  = r_ram_rd_ena;
  assign ram_wr_ena  = r_ram_wr_ena;
  assign ram_addr    = r_ram_addr;
  assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: transaction-level model with per-cycle expectations, a 4x4 RAM model,
// and directed literal checks. Build with RAM_CTRL_VERIFY_EN to exercise the verify path.
module tb_ram_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int NC    = 16384;
`ifdef RAM_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          req_err;
  logic          wr_err;
  logic          ram_rd_ena;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .req_err(req_err), .wr_err(wr_err),
    .ram_rd_ena(ram_rd_ena), .ram_wr_ena(ram_wr_ena), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM: registered data_out; both enables low clears the output and drops the write.
  logic [DW-1:0] ram_mem [4] = '{default: '0};
  logic [DW-1:0] ram_do = '0;
  bit            corrupt = 1'b0;
  assign ram_data_out = ram_do;

  always @(posedge clk) begin
    if (!ram_rd_ena && ram_wr_ena) ram_do <= ram_mem[ram_addr[1:0]];
    else if (ram_rd_ena && !ram_wr_ena)
      ram_mem[ram_addr[1:0]] <= (corrupt && ram_addr == 4'd1) ? (ram_data_in ^ 4'h1) : ram_data_in;
    else if (!ram_rd_ena && !ram_wr_ena) ram_do <= '0;
  end

  // Model state: per-cycle expectations indexed by the edge count after which they hold.
  int            cyc = 0;
  int            busy_until = 0;
  bit            exp_rsp_v [NC];
  logic [DW-1:0] exp_rdata_at [NC];
  bit            exp_req_err [NC];
  bit            exp_wr_err [NC];
  bit            exp_rd_low [NC];
  bit            exp_wr_low [NC];
  bit            exp_din_chk [NC];
  logic [AW-1:0] exp_addr [NC];
  logic [DW-1:0] exp_din [NC];
  logic [DW-1:0] mem_m [4] = '{default: '0};
  logic [DW-1:0] exp_rdata_cur = '0;
  bit            accepted = 1'b0;
  int            last_acc = 0;
  bit            chk_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] rsp_q [$];
  int            rsp_cyc_q [$];
  int            werr_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    accepted = 1'b0;
    if (cyc + 4 >= NC) begin
      $display("FAIL cycle_budget cyc=%0d actual=over required=under", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst_n && req_valid && (cyc - 1) >= busy_until) begin
      accepted = 1'b1;
      last_acc = cyc;
      if (int'(req_addr) >= DEPTH) begin
        exp_req_err[cyc] = 1'b1;
      end else if (req_wr) begin
        exp_wr_low[cyc] = 1'b1; exp_addr[cyc] = req_addr;
        exp_din[cyc] = req_wdata; exp_din_chk[cyc] = 1'b1;
        mem_m[req_addr[1:0]] = (corrupt && req_addr == 4'd1) ? (req_wdata ^ 4'h1) : req_wdata;
        if (VERIFY) begin
          exp_rd_low[cyc+1] = 1'b1; exp_addr[cyc+1] = req_addr;
          exp_din[cyc+1] = req_wdata; exp_din_chk[cyc+1] = 1'b1;
          if (corrupt && req_addr == 4'd1) exp_wr_err[cyc+3] = 1'b1;
          busy_until = cyc + 3;
        end else begin
          busy_until = cyc + 1;
        end
      end else begin
        exp_rd_low[cyc] = 1'b1; exp_addr[cyc] = req_addr;
        exp_rsp_v[cyc+2] = 1'b1; exp_rdata_at[cyc+2] = mem_m[req_addr[1:0]];
        busy_until = cyc + 2;
      end
    end
    if (exp_rsp_v[cyc]) exp_rdata_cur = exp_rdata_at[cyc];
  endtask

  task automatic model_clear();
    for (int i = cyc; i < cyc + 8; i++) begin
      exp_rsp_v[i] = 1'b0; exp_req_err[i] = 1'b0; exp_wr_err[i] = 1'b0;
      exp_rd_low[i] = 1'b0; exp_wr_low[i] = 1'b0; exp_din_chk[i] = 1'b0;
    end
    busy_until = cyc;
    exp_rdata_cur = '0;
  endtask

  task automatic compare_cycle();
    chk("req_ready", req_ready, cyc >= busy_until);
    chk("rsp_valid", rsp_valid, exp_rsp_v[cyc]);
    chk("rsp_rdata", rsp_rdata, exp_rdata_cur);
    chk("req_err", req_err, exp_req_err[cyc]);
    chk("wr_err", wr_err, exp_wr_err[cyc]);
    chk("ram_rd_ena", ram_rd_ena, !exp_rd_low[cyc]);
    chk("ram_wr_ena", ram_wr_ena, !exp_wr_low[cyc]);
    chk("enable_invariant", ram_rd_ena | ram_wr_ena, 1'b1);
    if (exp_rd_low[cyc] || exp_wr_low[cyc]) chk("ram_addr", ram_addr, exp_addr[cyc]);
    if (exp_din_chk[cyc]) chk("ram_data_in", ram_data_in, exp_din[cyc]);
    if (rsp_valid) begin
      rsp_q.push_back(rsp_rdata);
      rsp_cyc_q.push_back(cyc);
    end
    if (wr_err) werr_q.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_en) compare_cycle();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < 12; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    int base;
    int acc_q [$];
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_ena", ram_rd_ena, 1'b1);
    chk("rst_wr_ena", ram_wr_ena, 1'b1);
    chk("rst_addr", ram_addr, 4'h0);
    chk("rst_din", ram_data_in, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 4'h0);
    chk("rst_req_err", req_err, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    step(); step();
    rst_n = 1'b1;
    model_clear();
    chk_en = 1'b1;
    idle(2);

    // Reset arriving while a read is in its RD cycle abandons the access.
    base = rsp_q.size();
    issue(1'b0, 4'd0, 4'h0, 1'b0);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_ena", ram_rd_ena, 1'b1);
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_ready", req_ready, 1'b1);
    step();
    rst_n = 1'b1;
    model_clear();
    chk_en = 1'b1;
    idle(4);
    chk("rst_mid_no_rsp", rsp_q.size() - base, 0);

    // Write then read back one word.
    base = rsp_q.size();
    issue(1'b1, 4'd2, 4'hA, 1'b0);
    issue(1'b0, 4'd2, 4'h0, 1'b0);
    acc_q.push_back(last_acc);
    idle(5);
    chk("t2_rsp_count", rsp_q.size() - base, 1);
    chk("t2_rsp_data", rsp_q[base], 4'hA);
    chk("t2_rsp_latency", rsp_cyc_q[base] - acc_q[0], 2);

    // Back-to-back with req_valid held high.
    base = rsp_q.size();
    acc_q.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 4'(i), 4'(5 + i), 1'b1);
      acc_q.push_back(last_acc);
    end
    for (int i = 3; i >= 0; i--) begin
      issue(1'b0, 4'(i), 4'h0, i != 0);
      acc_q.push_back(last_acc);
    end
    idle(5);
    chk("t3_rsp_count", rsp_q.size() - base, 4);
    chk("t3_rsp0", rsp_q[base], 4'h8);
    chk("t3_rsp1", rsp_q[base+1], 4'h7);
    chk("t3_rsp2", rsp_q[base+2], 4'h6);
    chk("t3_rsp3", rsp_q[base+3], 4'h5);
    chk("t3_write_spacing", acc_q[1] - acc_q[0], VERIFY ? 4 : 2);
    chk("t3_read_spacing", acc_q[5] - acc_q[4], 3);

    // Out-of-range request is rejected without touching the RAM.
    base = rsp_q.size();
    issue(1'b0, 4'h7, 4'h0, 1'b0);
    chk("t4_req_err", req_err, 1'b1);
    chk("t4_rd_ena", ram_rd_ena, 1'b1);
    chk("t4_wr_ena", ram_wr_ena, 1'b1);
    chk("t4_ready", req_ready, 1'b1);
    issue(1'b1, 4'hF, 4'h3, 1'b0);
    chk("t4_wr_req_err", req_err, 1'b1);
    idle(4);
    chk("t4_no_rsp", rsp_q.size() - base, 0);
    chk("t4_mem_intact", mem_m[3], 4'h8);

    // Random traffic, including occasional out-of-range addresses and idle gaps.
    for (int n = 0; n < 1000; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 9) == 0) a = 4'($urandom_range(4, 15));
      else                           a = 4'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(5);

`ifdef RAM_CTRL_VERIFY_EN
    base = werr_q.size();
    corrupt = 1'b1;
    issue(1'b1, 4'd1, 4'h3, 1'b0);
    acc_q.delete();
    acc_q.push_back(last_acc);
    idle(6);
    corrupt = 1'b0;
    chk("t6_wr_err_count", werr_q.size() - base, 1);
    chk("t6_wr_err_latency", werr_q[base] - acc_q[0], 3);
    issue(1'b1, 4'd1, 4'h3, 1'b0);
    idle(6);
    chk("t6_clean_no_err", werr_q.size() - base, 1);
`else
    corrupt = 1'b1;
    issue(1'b1, 4'd1, 4'h3, 1'b0);
    idle(6);
    corrupt = 1'b0;
    chk("t6_wr_err_never", werr_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
